// File: rtl/sobel_stream_pkg.sv
// Shared definitions for the streaming Sobel controller: FSM state encoding and
// width helpers used to size the gradient datapath and the raster counters.
package sobel_stream_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t STREAM = 2'd1;
  localparam state_t DRAIN  = 2'd2;

  // Signed gradient width: worst case |G| = 4 * (2^PW - 1) plus a sign bit
  function automatic int unsigned grad_width(input int unsigned pixel_width);
    return pixel_width + 3;
  endfunction

  // Counter width able to hold 0..n-1
  function automatic int unsigned count_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage. Combinational read and synchronous write at
// the same address, so a read-before-write happens within each accepted pixel.
// Contents are intentionally not reset.
module sobel_line_buffer
  import sobel_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 160
) (
  input  logic                          clk,
  input  logic [count_width(DEPTH)-1:0] addr,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Write the new value after the old one has been read this cycle
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Streaming 3x3 Sobel filter: raster pixels in over valid/ready, one magnitude
// out per interior pixel with one cycle of latency. Two line buffers supply
// the upper rows of the sliding window.
// Optional build macro SOBEL_BINARIZE_EN: thresholds the magnitude to 0 / max.
module sobel_stream_ctrl
  import sobel_stream_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned IMAGE_WIDTH  = 160,
  parameter int unsigned IMAGE_HEIGHT = 120
`ifdef SOBEL_BINARIZE_EN
  ,
  parameter int unsigned SOBEL_THRESHOLD = 64
`endif
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   frame_start_i,
  input  logic                   px_valid_i,
  output logic                   px_ready_o,
  input  logic [PIXEL_WIDTH-1:0] px_data_i,
  output logic                   sobel_valid_o,
  input  logic                   sobel_ready_i,
  output logic [PIXEL_WIDTH-1:0] sobel_data_o,
  output logic                   frame_done_o,
  output logic                   busy_o
);

  localparam int unsigned GRAD_WIDTH = grad_width(PIXEL_WIDTH);
  localparam int unsigned COL_W      = count_width(IMAGE_WIDTH);
  localparam int unsigned ROW_W      = count_width(IMAGE_HEIGHT);
  localparam logic [GRAD_WIDTH:0] MAG_MAX = {4'b0000, {PIXEL_WIDTH{1'b1}}};

  typedef logic [PIXEL_WIDTH-1:0] window_t [3][3];

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q;
  logic [ROW_W-1:0]        row_q;
  window_t                 win_q, win_d;
  logic [PIXEL_WIDTH-1:0]  lb0_rd, lb1_rd;
  logic                    valid_q;
  logic [PIXEL_WIDTH-1:0]  data_q;
  logic                    accept, last_col, last_row, win_valid;
  logic signed [GRAD_WIDTH-1:0] gx, gy;
  logic [GRAD_WIDTH-1:0]   ax, ay;
  logic [GRAD_WIDTH:0]     mag_sum;
  logic [PIXEL_WIDTH-1:0]  mag_sat, out_pix;

  function automatic logic signed [GRAD_WIDTH-1:0] ext(input logic [PIXEL_WIDTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Ready depends only on state and the output slot, never on px_valid_i
  assign px_ready_o    = (state_q == STREAM) && (!valid_q || sobel_ready_i);
  assign accept        = px_valid_i && px_ready_o;
  assign last_col      = (col_q == COL_W'(IMAGE_WIDTH - 1));
  assign last_row      = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
  // Column test also blanks windows that straddle a line wrap
  assign win_valid     = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign sobel_valid_o = valid_q;
  assign sobel_data_o  = data_q;
  assign frame_done_o  = (state_q == DRAIN) && valid_q && sobel_ready_i;
  assign busy_o        = (state_q != IDLE);

  sobel_line_buffer #(
    .WIDTH (PIXEL_WIDTH),
    .DEPTH (IMAGE_WIDTH)
  ) u_line0 (
    .clk     (clk_i),
    .addr    (col_q),
    .wr_en   (accept),
    .wr_data (px_data_i),
    .rd_data (lb0_rd)
  );

  sobel_line_buffer #(
    .WIDTH (PIXEL_WIDTH),
    .DEPTH (IMAGE_WIDTH)
  ) u_line1 (
    .clk     (clk_i),
    .addr    (col_q),
    .wr_en   (accept),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Next window: shift left, new right column is two-lines-ago / last line / current pixel
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb1_rd;
    win_d[1][2] = lb0_rd;
    win_d[2][2] = px_data_i;
  end

  // Gradient kernel on the window that includes the pixel being accepted
  always_comb begin
    gx = (ext(win_d[0][2]) + (ext(win_d[1][2]) <<< 1) + ext(win_d[2][2]))
       - (ext(win_d[0][0]) + (ext(win_d[1][0]) <<< 1) + ext(win_d[2][0]));
    gy = (ext(win_d[2][0]) + (ext(win_d[2][1]) <<< 1) + ext(win_d[2][2]))
       - (ext(win_d[0][0]) + (ext(win_d[0][1]) <<< 1) + ext(win_d[0][2]));
    ax = gx[GRAD_WIDTH-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[GRAD_WIDTH-1] ? $unsigned(-gy) : $unsigned(gy);
    mag_sum = {1'b0, ax} + {1'b0, ay};
    mag_sat = (mag_sum > MAG_MAX) ? {PIXEL_WIDTH{1'b1}} : mag_sum[PIXEL_WIDTH-1:0];
`ifdef SOBEL_BINARIZE_EN
    out_pix = ({4'b0000, mag_sat} >= (GRAD_WIDTH + 1)'(SOBEL_THRESHOLD)) ?
              {PIXEL_WIDTH{1'b1}} : '0;
`else
    out_pix = mag_sat;
`endif
  end

  // FSM next state; a frame_start_i outside IDLE is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start_i) state_d = STREAM;
      STREAM:  if (accept && last_col && last_row) state_d = DRAIN;
      DRAIN:   if (valid_q && sobel_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Raster counters and window, advanced once per accepted pixel
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_q <= '0;
      row_q <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      end
    end else if ((state_q == IDLE) && frame_start_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      win_q <= win_d;
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Output register: load on a valid window, hold while stalled, clear when consumed
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (accept && win_valid) begin
      valid_q <= 1'b1;
      data_q  <= out_pix;
    end else if (sobel_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Scoreboard bench for sobel_stream_ctrl on an 8x6 image: the driver pushes
// expected magnitudes from a whole-image convolution model, the monitor pops
// and compares every accepted output.
module tb_sobel_stream_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;
  localparam int MAXV = (1 << PW) - 1;
  localparam int N_OUT = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          frame_start = 1'b0;
  logic          px_valid = 1'b0;
  logic          px_ready;
  logic [PW-1:0] px_data = '0;
  logic          sobel_valid;
  logic          sobel_ready = 1'b1;
  logic [PW-1:0] sobel_data;
  logic          frame_done;
  logic          busy;

  sobel_stream_ctrl #(
    .PIXEL_WIDTH  (PW),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clk_i         (clk),
    .nreset_i      (nreset),
    .frame_start_i (frame_start),
    .px_valid_i    (px_valid),
    .px_ready_o    (px_ready),
    .px_data_i     (px_data),
    .sobel_valid_o (sobel_valid),
    .sobel_ready_i (sobel_ready),
    .sobel_data_o  (sobel_data),
    .frame_done_o  (frame_done),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passes = 0;
  int exp_q[$];
  int img[H][W];
  int out_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int stall_from = -100;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: Sobel magnitude at interior center (r, c) of img
  function automatic int ref_px(input int r, input int c);
    int gx, gy, m;
    gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > MAXV) m = MAXV;
`ifdef SOBEL_BINARIZE_EN
    m = (m >= 64) ? MAXV : 0;
`endif
    return m;
  endfunction

  // Downstream ready: random, or high except for a 5-cycle stall window
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (rand_ready) sobel_ready = ($urandom_range(0, 3) != 0);
    else            sobel_ready = !(cyc >= stall_from && cyc < stall_from + 5);
  end

  // Monitor: scoreboard compare, hold stability, backpressure, frame_done count
  initial begin
    bit hold_armed;
    int hold_val;
    hold_armed = 1'b0;
    hold_val = 0;
    forever begin
      @(negedge clk);
      if (hold_armed && sobel_valid) chk("hold_data", int'(sobel_data), hold_val);
      if (sobel_valid && !sobel_ready) chk("px_ready_stalled", int'(px_ready), 0);
      hold_armed = sobel_valid && !sobel_ready;
      hold_val = int'(sobel_data);
      if (sobel_valid && sobel_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) chk("unexpected_output", int'(sobel_data), -1);
        else chk("sobel_data", int'(sobel_data), exp_q.pop_front());
      end
      if (frame_done) done_cnt++;
    end
  end

  // kind: 0 uniform 100, 1 step edge, 2 ramp 10*col, 3 random
  task automatic run_frame(input int kind, input int abort_at, input int glitch_at,
                           input bit rnd_valid, input bit check_done);
    int n_pix, snap_out, snap_done, tmo;
    bit ok;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c < 4) ? 0 : 255;
          2:       img[r][c] = 10 * c;
          default: img[r][c] = int'($urandom_range(0, MAXV));
        endcase
      end
    end
    n_pix = (abort_at > 0) ? abort_at : W * H;
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        if ((r + 1) * W + c + 1 < n_pix) exp_q.push_back(ref_px(r, c));
      end
    end
    snap_out = out_cnt;
    snap_done = done_cnt;
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    for (int i = 0; i < n_pix; i++) begin
      if (rnd_valid && $urandom_range(0, 3) == 0) begin
        px_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      px_valid = 1'b1;
      px_data = PW'(img[i / W][i % W]);
      frame_start = (i == glitch_at);
      ok = 1'b0;
      tmo = 0;
      while (!ok && tmo < 200) begin
        @(negedge clk);
        if (px_ready) ok = 1'b1;
        else tmo++;
      end
      if (!ok) begin
        chk("px_accept_timeout", i, -1);
        break;
      end
      @(posedge clk);
      #1 frame_start = 1'b0;
    end
    px_valid = 1'b0;
    if (abort_at > 0) begin
      repeat (2) @(posedge clk);
      #1 nreset = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(sobel_valid), 0);
      chk("abort_px_ready", int'(px_ready), 0);
      repeat (3) @(posedge clk);
      #1 nreset = 1'b1;
      chk("abort_outputs", out_cnt - snap_out, n_pix > 2 * W + 2 ? (n_pix - 2 * W - 2) : 0);
      chk("abort_queue_empty", exp_q.size(), 0);
      return;
    end
    if (check_done) chk("frame_done_timing", int'(frame_done), 1);
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (busy && tmo < 300);
    chk("frame_end_busy", int'(busy), 0);
    @(negedge clk);
    chk("frame_outputs", out_cnt - snap_out, N_OUT);
    chk("frame_done_count", done_cnt - snap_done, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #23;
    chk("reset_busy", int'(busy), 0);
    chk("reset_px_ready", int'(px_ready), 0);
    chk("reset_valid", int'(sobel_valid), 0);
    chk("reset_data", int'(sobel_data), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_px_ready", int'(px_ready), 0);

    run_frame(0, 0, -1, 1'b0, 1'b1);   // uniform
    run_frame(1, 0, -1, 1'b0, 1'b1);   // vertical step edge
    run_frame(2, 0, -1, 1'b0, 1'b1);   // ramp
    stall_from = cyc + 25;              // downstream stall mid-frame
    run_frame(2, 0, -1, 1'b0, 1'b0);
    stall_from = -100;
    run_frame(2, 20, -1, 1'b0, 1'b0);  // reset after 20 pixels
    run_frame(2, 0, -1, 1'b0, 1'b1);   // clean ramp after reset
    run_frame(2, 0, 10, 1'b0, 1'b1);   // frame_start during STREAM
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) run_frame(3, 0, -1, 1'b1, 1'b0);
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, total);
    $fatal(1);
  end

endmodule

// File: doc/sobel_stream_ctrl.md
Name: sobel_stream_ctrl

Overview:
Streaming successor to the single-window Sobel controller. It accepts a raster-order grayscale pixel stream over a valid/ready handshake, holds two full image lines in internal line buffers and keeps a sliding 3x3 window. It emits one Sobel magnitude per interior pixel, so every input pixel is read exactly once instead of nine times. It sits between the grayscale preprocessing stage and the output SPI/pixel sink. Image geometry and pixel width are parametrised.

Parameters:
PIXEL_WIDTH, 8, bits per grayscale and output pixel
IMAGE_WIDTH, 160, pixels per line (>=3)
IMAGE_HEIGHT, 120, lines per frame (>=3)

Ports:
clk_i  in  1  single clock
nreset_i  in  1  asynchronous active-low reset
frame_start_i  in  1  one-cycle pulse; legal only in IDLE; arms a new frame
px_valid_i  in  1  input pixel valid
px_ready_o  out  1  block can accept a pixel this cycle
px_data_i  in  PIXEL_WIDTH  grayscale pixel, raster order
sobel_valid_o  out  1  output pixel valid
sobel_ready_i  in  1  downstream accepts output
sobel_data_o  out  PIXEL_WIDTH  Sobel magnitude
frame_done_o  out  1  one-cycle pulse when the last output of a frame is accepted
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async, nreset_i low): FSM = IDLE; row/col counters = 0; window = 0; px_ready_o = 0; sobel_valid_o = 0; sobel_data_o = 0; frame_done_o = 0; busy_o = 0. Line buffer contents are not reset.
- FSM states:
  - IDLE -> STREAM on frame_start_i.
  - STREAM -> DRAIN when the last input pixel (row H-1, col W-1) is accepted.
  - DRAIN -> IDLE when the final output is accepted; frame_done_o pulses in that same cycle.
- Input accept: a pixel is taken when px_valid_i && px_ready_o.
  - px_ready_o = (state == STREAM) && (!sobel_valid_o || sobel_ready_i).
  - No combinational path from px_valid_i to px_ready_o.
- On each accepted pixel:
  - Shift the window left by one column.
  - New right column = {linebuf1[col], linebuf0[col], px_data_i}, top to bottom.
  - Write linebuf1[col] <= linebuf0[col] and linebuf0[col] <= px_data_i.
  - Advance col; wrap at W-1 to 0 and increment row.
- Window valid when the accepted pixel has row >= 2 and col >= 2.
  - sobel_data_o and sobel_valid_o are registered on the next clock (latency 1 cycle).
  - The output corresponds to center (row-1, col-1).
  - Exactly (W-2)*(H-2) outputs per frame; border pixels produce no output.
- At col wrap the window columns from the previous line must not combine with the new line. Outputs are suppressed until col >= 2 again.
- Arithmetic, with p[r][c], r=0 the top row and c=0 the left column:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
  - Both are signed, PIXEL_WIDTH+3 bits.
  - mag = |Gx| + |Gy|, saturated to 2^PIXEL_WIDTH - 1.
- Output hold: while sobel_valid_o && !sobel_ready_i, sobel_data_o is stable and no input is accepted.
- frame_start_i outside IDLE is ignored.
- Async reset mid-frame discards the frame. The next frame needs a fresh frame_start_i.

Optional Feature:
SOBEL_BINARIZE_EN
- Defined: adds parameter SOBEL_THRESHOLD (default 64). Output = (mag >= SOBEL_THRESHOLD) ? 2^PIXEL_WIDTH-1 : 0.
- Undefined: the saturated magnitude is output unchanged.
- Latency and handshake are identical in both builds.

Decomposition:
- Package sobel_stream_pkg holds:
  - FSM state enum (IDLE, STREAM, DRAIN).
  - Window typedef: 3x3 array of PIXEL_WIDTH.
  - Signed gradient width constant GRAD_WIDTH = PIXEL_WIDTH+3.
  - Counter width functions: $clog2 of IMAGE_WIDTH and IMAGE_HEIGHT.
- Sub-module sobel_line_buffer: single-port-per-line storage of depth IMAGE_WIDTH with one read and one write per accepted pixel at the same address.
- The gradient kernel stays combinational inside the top module.

Test Plan:
- W=8, H=6, PW=8, uniform image of value 100, px_valid_i always high, sobel_ready_i always high -> 24 outputs, all 0; frame_done_o pulses once, one cycle after the 48th pixel is accepted.
- W=8, H=6, columns 0..3 = 0 and columns 4..7 = 255 -> output 255 at center cols 3 and 4, 0 at center cols 1, 2, 5, 6, on every interior row.
- Horizontal ramp with pixel = 10*col -> every output = 80 (Gx=80, Gy=0); with SOBEL_BINARIZE_EN and threshold 64 -> every output = 255.
- Hold sobel_ready_i low for 5 cycles mid-frame -> px_ready_o low within 1 cycle, sobel_data_o stable, no pixel lost; output sequence identical to the unstalled run.
- Pulse nreset_i low after 20 pixels, then issue frame_start_i and send a full ramp frame -> outputs match the clean-frame reference, exactly 24 outputs.
- frame_start_i pulsed during STREAM -> ignored; frame completes normally with one frame_done_o pulse.
